// File: rtl/mmio_irq_pkg.sv
// Shared constants for the memory-mapped interrupt/timer block: register offsets,
// pending-bit positions and CTRL field layout.
package mmio_irq_pkg;

    localparam logic [2:0] OFF_COUNT   = 3'd0;
    localparam logic [2:0] OFF_COMPARE = 3'd1;
    localparam logic [2:0] OFF_CTRL    = 3'd2;
    localparam logic [2:0] OFF_PENDING = 3'd3;
    localparam logic [2:0] OFF_MASK    = 3'd4;
    localparam logic [2:0] OFF_SWSET   = 3'd5;

    localparam int IRQ_TIMER = 0;
    localparam int IRQ_SW    = 1;
    localparam int IRQ_EXT0  = 2;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;

    typedef struct packed {
        logic reload;
        logic enable;
    } ctrl_t;

endpackage

// File: rtl/mmio_irq_timer_sync_edge.sv
// Two-flop synchroniser for one asynchronous request line, followed by a
// rising-edge detector producing a single-cycle pulse.
module irq_sync_edge (
    input  logic ph1,
    input  logic reset_b,
    input  logic async_in,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= async_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/mmio_irq_timer.sv
// Memory-mapped interrupt source: compare timer, software trigger and external
// request lines feeding a pending/mask pair that drives the CPU interrupts input.
module mmio_irq_timer
    import mmio_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          NUM_EXT   = 6,
    parameter int          PRESCALE  = 1
) (
    input  logic               ph1,
    input  logic               reset_b,
    input  logic               memwrite,
    input  logic [31:0]        dataadr,
    input  logic [31:0]        writedata,
    input  logic [NUM_EXT-1:0] ext_irq,
    output logic               hit,
    output logic [31:0]        readdata,
    output logic [7:0]         interrupts
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [31:0]        count_reg, count_next;
    logic [31:0]        compare_reg, compare_next;
    ctrl_t              ctrl_reg, ctrl_next;
    logic [7:0]         pending_reg, pending_next;
    logic [7:0]         mask_reg, mask_next;
    logic [PW-1:0]      presc_reg, presc_next;
    logic               tick;
    logic               we;
    logic [2:0]         off;
    logic [7:0]         set_vec;
    logic [7:0]         clr_vec;
    logic [NUM_EXT-1:0] ext_edge;
    logic               unused_addr_bits;

    assign hit = (dataadr[31:5] == BASE_ADDR[31:5]);
    assign we  = memwrite & hit;
    assign off = dataadr[4:2];
    // Byte lane is irrelevant: only full-word stores are decoded.
    assign unused_addr_bits = ^dataadr[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EXT; gi++) begin : g_ext
            irq_sync_edge u_sync (
                .ph1      (ph1),
                .reset_b  (reset_b),
                .async_in (ext_irq[gi]),
                .pulse    (ext_edge[gi])
            );
        end
    endgenerate

    assign tick = ctrl_reg.enable && (presc_reg == PW'(PRESCALE - 1));

    always_comb begin
        presc_next = presc_reg;
        if (!ctrl_reg.enable || tick)
            presc_next = '0;
        else
            presc_next = presc_reg + PW'(1);
    end

    always_comb begin
        count_next   = count_reg;
        compare_next = compare_reg;
        ctrl_next    = ctrl_reg;
        mask_next    = mask_reg;
        set_vec      = '0;
        clr_vec      = '0;

        // Match is judged on the pre-write COUNT/COMPARE even when the CPU writes them.
        set_vec[IRQ_TIMER]           = tick && (count_reg == compare_reg);
        set_vec[IRQ_EXT0 +: NUM_EXT] = ext_edge;

        if (tick)
            count_next = ctrl_reg.reload ? 32'd0 : count_reg + 32'd1;

        if (we) begin
            case (off)
                OFF_COUNT:   count_next   = writedata;
                OFF_COMPARE: compare_next = writedata;
                OFF_CTRL:    ctrl_next    = ctrl_t'(writedata[1:0]);
                OFF_PENDING: clr_vec      = writedata[7:0];
                OFF_MASK:    mask_next    = writedata[7:0];
                OFF_SWSET:   set_vec[IRQ_SW] = writedata[0];
                default: ;
            endcase
        end

        pending_next = (pending_reg & ~clr_vec) | set_vec;
    end

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            count_reg   <= 32'd0;
            compare_reg <= 32'hFFFF_FFFF;
            ctrl_reg    <= '0;
            pending_reg <= 8'h00;
            mask_reg    <= 8'h00;
            presc_reg   <= '0;
            interrupts  <= 8'h00;
        end else begin
            count_reg   <= count_next;
            compare_reg <= compare_next;
            ctrl_reg    <= ctrl_next;
            pending_reg <= pending_next;
            mask_reg    <= mask_next;
            presc_reg   <= presc_next;
            interrupts  <= pending_next & mask_next;
        end
    end

    always_comb begin
        readdata = 32'd0;
        if (hit) begin
            case (off)
                OFF_COUNT:   readdata = count_reg;
                OFF_COMPARE: readdata = compare_reg;
                OFF_CTRL:    readdata = {30'd0, ctrl_reg};
                OFF_PENDING: readdata = {24'd0, pending_reg};
                OFF_MASK:    readdata = {24'd0, mask_reg};
                default:     readdata = {31'd0, unused_addr_bits & 1'b0};
            endcase
        end
    end

endmodule
